bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 128 ++++++++++++
 tb/tb_bus_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: CPU (m0) and DMA (m1) share one device bridge port.
// Round-robin on ties by default; define ARB_FIXED_PRIO_EN for fixed m0 priority.
module bus_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:2] m0_addr,
    input  logic [31:0] m0_wd,
    input  logic        m0_we,
    output logic        m0_ack,
    output logic [31:0] m0_rd,
    input  logic        m1_req,
    input  logic [31:2] m1_addr,
    input  logic [31:0] m1_wd,
    input  logic        m1_we,
    output logic        m1_ack,
    output logic [31:0] m1_rd,
    output logic [31:2] PrAddr,
    output logic [31:0] PrWD,
    output logic        PrWE,
    input  logic [31:0] PrRD,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } state_t;

    state_t      state;
    state_t      nstate;
    logic [31:2] lat_addr;
    logic [31:0] lat_wd;
    logic        lat_we;
    logic        m0_live;
    logic        m1_live;
    logic        pick1;

    // A master whose ack is showing this cycle is still holding req; skip it.
    assign m0_live = m0_req & ~m0_ack;
    assign m1_live = m1_req & ~m1_ack;

`ifdef ARB_FIXED_PRIO_EN
    assign pick1 = m1_live & ~m0_live;
`else
    logic last;

    assign pick1 = m1_live & (~m0_live | ~last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= 1'b1;
        end else if (state == SERVE0) begin
            last <= 1'b0;
        end else if (state == SERVE1) begin
            last <= 1'b1;
        end
    end
`endif

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE: begin
                if (pick1) begin
                    nstate = SERVE1;
                end else if (m0_live) begin
                    nstate = SERVE0;
                end
            end
            SERVE0:  nstate = IDLE;
            SERVE1:  nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_addr <= '0;
            lat_wd   <= '0;
            lat_we   <= 1'b0;
        end else if (state == IDLE && nstate == SERVE0) begin
            lat_addr <= m0_addr;
            lat_wd   <= m0_wd;
            lat_we   <= m0_we;
        end else if (state == IDLE && nstate == SERVE1) begin
            lat_addr <= m1_addr;
            lat_wd   <= m1_wd;
            lat_we   <= m1_we;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            m0_rd  <= '0;
            m1_rd  <= '0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            if (state == SERVE0) begin
                m0_ack <= 1'b1;
                m0_rd  <= PrRD;
            end
            if (state == SERVE1) begin
                m1_ack <= 1'b1;
                m1_rd  <= PrRD;
            end
        end
    end

    // Decoded from state so an asynchronous reset kills the strobe at once.
    assign busy   = (state != IDLE);
    assign PrWE   = busy & lat_we;
    assign PrAddr = lat_addr;
    assign PrWD   = lat_wd;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed stimulus pushes expected acks,
// a negedge monitor pops and compares each ack the DUT presents.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req;
    logic [31:2] m0_addr, m1_addr;
    logic [31:0] m0_wd, m1_wd;
    logic        m0_we, m1_we;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rd, m1_rd;
    logic [31:2] pr_addr;
    logic [31:0] pr_wd;
    logic        pr_we;
    logic [31:0] pr_rd;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int c;

    typedef struct {
        bit          m;
        logic [31:0] rd;
        int          cyc;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Device model: one magic word, otherwise byte address xor a tag.
    assign pr_rd = (pr_addr == 30'h1FC3) ? 32'hDEAD_BEEF
                 : ({pr_addr, 2'b00} ^ 32'hA5A5_0000);

    bus_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m0_we(m0_we), .m0_ack(m0_ack), .m0_rd(m0_rd),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m1_we(m1_we), .m1_ack(m1_ack), .m1_rd(m1_rd),
        .PrAddr(pr_addr), .PrWD(pr_wd), .PrWE(pr_we),
        .PrRD(pr_rd), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit m, input logic [31:0] rd, input int cy);
        exp_t e;
        e.m = m;
        e.rd = rd;
        e.cyc = cy;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && (m0_ack || m1_ack)) begin
            exp_t e;
            logic [31:0] rd;
            vectors++;
            rd = m1_ack ? m1_rd : m0_rd;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL ack: unexpected ack m0=%0b m1=%0b rd=%h cycle %0d",
                         m0_ack, m1_ack, rd, cyc);
            end else begin
                e = q.pop_front();
                if ((m0_ack && m1_ack) || (m1_ack != e.m) ||
                    (rd !== e.rd) || (cyc != e.cyc)) begin
                    miscompares++;
                    $display("FAIL ack: got m0=%0b m1=%0b rd=%h cyc=%0d expected m%0d rd=%h cyc=%0d",
                             m0_ack, m1_ack, rd, cyc, e.m, e.rd, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        m0_req = 0; m0_addr = '0; m0_wd = '0; m0_we = 0;
        m1_req = 0; m1_addr = '0; m1_wd = '0; m1_we = 0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_prwe", pr_we, 0);
        check("rst_praddr", pr_addr, 0);
        check("rst_prwd", pr_wd, 0);
        check("rst_m0ack", m0_ack, 0);
        check("rst_m1ack", m1_ack, 0);
        check("rst_m0rd", m0_rd, 0);
        check("rst_m1rd", m1_rd, 0);
        tick();
        reset = 1'b0;
        tick();

        // single read by m0
        tick();
        c = cyc;
        m0_req = 1; m0_addr = 30'h1FC3; m0_we = 0; m0_wd = 32'h1111_1111;
        push(0, 32'hDEAD_BEEF, c + 2);
        tick();
        @(negedge clk);
        check("rd_prwe", pr_we, 0);
        check("rd_busy", busy, 1);
        check("rd_praddr", pr_addr, 30'h1FC3);
        @(negedge clk);
        m0_req = 0;
        repeat (2) tick();

        // single write by m1
        tick();
        c = cyc;
        m1_req = 1; m1_addr = 30'h1FCE; m1_wd = 32'h0000_00A5; m1_we = 1;
        push(1, 32'hA5A5_7F38, c + 2);
        tick();
        @(negedge clk);
        check("wr_prwe", pr_we, 1);
        check("wr_praddr", pr_addr, 30'h1FCE);
        check("wr_prwd", pr_wd, 32'h0000_00A5);
        @(negedge clk);
        check("wr_prwe_off", pr_we, 0);
        m1_req = 0; m1_we = 0;
        repeat (2) tick();

        // m0 holds req through its ack: no grant in the ack cycle
        tick();
        c = cyc;
        m0_req = 1; m0_addr = 30'h040; m0_we = 0;
        push(0, 32'hA5A5_0100, c + 2);
        push(0, 32'hA5A5_0100, c + 5);
        tick();
        repeat (3) @(negedge clk);
        check("mask_idle", busy, 0);
        @(negedge clk);
        check("mask_regrant", busy, 1);
        m0_req = 0;
        repeat (3) tick();

        // operand change while in flight
        tick();
        c = cyc;
        m0_req = 1; m0_addr = 30'h0AA; m0_we = 0;
        push(0, 32'hA5A5_02A8, c + 2);
        tick();
        @(negedge clk);
        m0_addr = 30'h155;
        #1;
        check("op_praddr_serve", pr_addr, 30'h0AA);
        @(negedge clk);
        check("op_praddr_idle", pr_addr, 30'h0AA);
        m0_req = 0;
        repeat (2) tick();

        // reset during a SERVE1 write
        tick();
        m1_req = 1; m1_addr = 30'h0BB; m1_wd = 32'h1234; m1_we = 1;
        tick();
        @(negedge clk);
        check("rstop_prwe_pre", pr_we, 1);
        reset = 1'b1;
        #1;
        check("rstop_prwe", pr_we, 0);
        check("rstop_busy", busy, 0);
        m1_req = 0; m1_we = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("rstop_no_ack", m1_ack, 0);
        end

        // contention from reset: acks alternate m0, m1, ...
        reset = 1'b1;
        m0_req = 1; m0_addr = 30'h100; m0_we = 0;
        m1_req = 1; m1_addr = 30'h200; m1_we = 0;
        tick();
        reset = 1'b0;
        c = cyc;
        for (int k = 0; k < 4; k++) begin
            push(0, 32'hA5A5_0400, c + 2 + 4 * k);
            push(1, 32'hA5A5_0800, c + 4 + 4 * k);
        end
        do @(negedge clk); while (cyc < c + 16);
        m0_req = 0; m1_req = 0;

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending acks expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
